rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4_if.sv | 12 +
 rtl/rr_arbiter4.sv | 116 +++++++++++
 tb/tb_rr_arbiter4.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// master = requester side (drives req), slave = arbiter side (drives grant outputs).
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  modport master (output req, input gnt, gnt_id, busy, preempt);
  modport slave  (input req, output gnt, gnt_id, busy, preempt);
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with hold timeout; grant registered, 1-cycle latency from req.
// No backpressure: a holder keeps the grant until it releases or is preempted after MAX_HOLD cycles.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  rr_arbiter4_if.slave       arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t      state_q,   state_d;
  logic [1:0]  ptr_q,     ptr_d;
  logic [3:0]  hcnt_q,    hcnt_d;
  logic [3:0]  gnt_q,     gnt_d;
  logic [1:0]  gnt_id_q,  gnt_id_d;
  logic        busy_q,    busy_d;
  logic        preempt_q, preempt_d;

  logic [3:0]  others;
  logic        waiting;
  logic        hold_req;
  logic        timeout;
  logic [2:0]  sel;

  // Returns {found, index} of the first set bit of r, searching p, p+1, p+2, p+3 mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      c = p + 2'(i);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    others    = arb.req & ~gnt_q;
    waiting   = |others;
    hold_req  = arb.req[gnt_id_q];
    timeout   = 1'b0;
    sel       = 3'b000;

    case (state_q)
      IDLE: begin
        sel = pick(arb.req, ptr_q);
        if (sel[2]) begin
          state_d  = GRANT;
          gnt_d    = 4'b0001 << sel[1:0];
          gnt_id_d = sel[1:0];
          busy_d   = 1'b1;
          hcnt_d   = 4'd0;
        end
      end
      GRANT: begin
        timeout = hold_req && waiting && (hcnt_q == HOLD_LAST);
        if (!hold_req || timeout) begin
          // Holder is excluded so a preempted requester cannot win straight back.
          ptr_d     = gnt_id_q + 2'd1;
          sel       = pick(others, ptr_d);
          preempt_d = timeout;
          hcnt_d    = 4'd0;
          if (sel[2]) begin
            gnt_d    = 4'b0001 << sel[1:0];
            gnt_id_d = sel[1:0];
          end else begin
            state_d  = IDLE;
            gnt_d    = 4'b0000;
            gnt_id_d = 2'd0;
            busy_d   = 1'b0;
          end
        end else if (waiting) begin
          hcnt_d = hcnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      hcnt_q    <= 4'd0;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign arb.gnt     = gnt_q;
  assign arb.gnt_id  = gnt_id_q;
  assign arb.busy    = busy_q;
  assign arb.preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: reset, single requester, round-robin, timeout,
// sole holder, wrap-around and asynchronous reset mid-grant.
module tb_rr_arbiter4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rr_arbiter4_if ifc ();

  rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {gnt, gnt_id, busy, preempt} against the expected grant state.
  task automatic chk(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                     input logic e_busy, input logic e_pre);
    logic [7:0] got;
    logic [7:0] exp;
    got = {ifc.gnt, ifc.gnt_id, ifc.busy, ifc.preempt};
    exp = {e_gnt, e_id, e_busy, e_pre};
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: gnt/id/busy/pre got=%b_%0d_%b_%b expected=%b_%0d_%b_%b",
               tag, got[7:4], got[3:2], got[1], got[0], exp[7:4], exp[3:2], exp[1], exp[0]);
      end
  endtask

  initial begin
    logic [3:0] one_hot;
    logic [3:0] nxt;
    ifc.req = 4'b0000;

    // Reset state held across clock edges
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Round-robin with req=1111, each holder releases after 2 cycles (ptr=0 after reset)
    ifc.req = 4'b1111;
    tick();
    chk("rr_first_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      one_hot = 4'b0001 << k;
      nxt     = 4'b0001 << ((k + 1) % 4);
      tick();
      chk("rr_hold", one_hot, 2'(k), 1'b1, 1'b0);
      ifc.req = 4'b1111 & ~one_hot;
      tick();
      chk("rr_next", nxt, 2'((k + 1) % 4), 1'b1, 1'b0);
      ifc.req = 4'b1111;
    end
    ifc.req = 4'b0000;
    tick();
    chk("rr_release_all", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester (ptr=1): grant 2 one edge later, drop one edge after release
    ifc.req = 4'b0100;
    tick();
    chk("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    ifc.req = 4'b0000;
    tick();
    chk("single_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Timeout with req=0011 held (ptr=3 -> search 3,0 picks 0)
    ifc.req = 4'b0011;
    tick();
    chk("to_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk("to_preempt_to1", 4'b0010, 2'd1, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    chk("to_preempt_to0", 4'b0001, 2'd0, 1'b1, 1'b1);
    tick();
    chk("to_pulse_end", 4'b0001, 2'd0, 1'b1, 1'b0);
    ifc.req = 4'b0000;
    tick();
    chk("to_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Sole holder: no timeout ever
    ifc.req = 4'b1000;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("sole_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    end

    // Wrap-around: holder 3 releases while 0 and 2 request
    ifc.req = 4'b0101;
    tick();
    chk("wrap_to0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges during a grant
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    ifc.req = 4'b0010;
    tick();
    chk("post_reset_grant", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
